// File: rtl/demux16_pkg.sv
// rtl/demux16_pkg.sv - shared defaults and channel-select type for the two-way stream demux
package demux16_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 2;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_sel_e;

endpackage

// File: rtl/demux16_fifo.sv
// rtl/demux16_fifo.sv - per-channel synchronous FIFO with occupancy count
module demux16_fifo
    import demux16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/demux16_stream.sv
// rtl/demux16_stream.sv - routes one input stream into two buffered output channels
module demux16_stream
    import demux16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sel,
    output logic                   out0_valid,
    input  logic                   out0_ready,
    output logic [WIDTH-1:0]       out0_data,
    output logic [$clog2(DEPTH):0] out0_count,
    output logic                   out1_valid,
    input  logic                   out1_ready,
    output logic [WIDTH-1:0]       out1_data,
    output logic [$clog2(DEPTH):0] out1_count,
    output logic [15:0]            drop_cnt
);

    logic    full0, full1, empty0, empty1;
    logic    push0, push1, pop0, pop1;
    logic    xfer;
    ch_sel_e sel;

    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign sel = ch_sel_e'(in_sel);

    // Ready looks only at registered fullness, so a full channel cannot
    // take a word in the same cycle it pops one.
    assign in_ready = (sel == CH1) ? !full1 : !full0;
    assign xfer     = in_valid && in_ready;
    assign push0    = xfer && (sel == CH0);
    assign push1    = xfer && (sel == CH1);
    assign pop0     = !empty0 && out0_ready;
    assign pop1     = !empty1 && out1_ready;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_valid && !in_ready && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    demux16_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .pop   (pop0),
        .wdata (in_data),
        .rdata (out0_data),
        .count (out0_count),
        .full  (full0),
        .empty (empty0)
    );

    demux16_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .pop   (pop1),
        .wdata (in_data),
        .rdata (out1_data),
        .count (out1_count),
        .full  (full1),
        .empty (empty1)
    );

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_demux16_stream.sv
// tb/tb_demux16_stream.sv - directed self-checking bench for demux16_stream
module tb_demux16_stream;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sel;
    logic        out0_valid, out1_valid;
    logic        out0_ready, out1_ready;
    logic [15:0] out0_data, out1_data;
    logic [1:0]  out0_count, out1_count;
    logic [15:0] drop_cnt;

    int pass_cnt  = 0;
    int check_cnt = 0;

    demux16_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_count (out0_count),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_count (out1_count),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int rcvd;
        int cycles;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        tick();
        tick();
        check("rst_out0_valid", 32'(out0_valid), 32'd0);
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out0_count", 32'(out0_count), 32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_drop_cnt",   32'(drop_cnt),   32'd0);
        rst_n = 1'b1;

        // Route
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1234;
        #1 check("route_ready0", 32'(in_ready), 32'd1);
        tick();
        check("route_out0_valid", 32'(out0_valid), 32'd1);
        check("route_out0_data",  32'(out0_data),  32'h1234);
        check("route_out0_count", 32'(out0_count), 32'd1);
        in_sel = 1'b1; in_data = 16'hABCD;
        tick();
        check("route_out0_drained", 32'(out0_count), 32'd0);
        check("route_out1_valid",   32'(out1_valid), 32'd1);
        check("route_out1_data",    32'(out1_data),  32'hABCD);
        in_valid = 1'b0;
        tick();
        check("route_out1_drained", 32'(out1_count), 32'd0);
        check("route_drop",         32'(drop_cnt),   32'd0);

        // Full
        out0_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0001;
        tick();
        check("full_count1", 32'(out0_count), 32'd1);
        in_data = 16'h0002;
        tick();
        check("full_count2", 32'(out0_count), 32'd2);
        in_data = 16'h0003;
        #1 check("full_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("full_drop1",  32'(drop_cnt),   32'd1);
        check("full_count_hold", 32'(out0_count), 32'd2);
        tick();
        check("full_drop2",  32'(drop_cnt),   32'd2);
        check("full_head",   32'(out0_data),  32'h0001);

        // Full with pop: pop this edge, word 3 still refused
        out0_ready = 1'b1;
        #1 check("fpop_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("fpop_count",  32'(out0_count), 32'd1);
        check("fpop_drop",   32'(drop_cnt),   32'd3);
        check("fpop_head",   32'(out0_data),  32'h0002);
        out0_ready = 1'b0;
        #1 check("fpop_ready_high", 32'(in_ready), 32'd1);
        tick();
        check("fpop_accept_count", 32'(out0_count), 32'd2);
        check("fpop_accept_drop",  32'(drop_cnt),   32'd3);

        // Cross traffic while channel 0 is full and blocked
        in_sel = 1'b1; in_data = 16'h55AA; out1_ready = 1'b0;
        #1 check("cross_ready", 32'(in_ready), 32'd1);
        tick();
        check("cross_out1_valid", 32'(out1_valid), 32'd1);
        check("cross_out1_data",  32'(out1_data),  32'h55AA);
        check("cross_drop",       32'(drop_cnt),   32'd3);
        in_valid = 1'b0; out1_ready = 1'b1;
        tick();
        check("cross_drained", 32'(out1_count), 32'd0);

        // Wrap: ten words through channel 1 with random backpressure
        sent = 0; rcvd = 0; cycles = 0;
        while (rcvd < 10 && cycles < 300) begin
            in_valid   = (sent < 10);
            in_sel     = 1'b1;
            in_data    = 16'(sent);
            out1_ready = 1'($urandom_range(1));
            #1;
            if (out1_valid && out1_ready) begin
                check("wrap_order", 32'(out1_data), 32'(rcvd));
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cycles++;
        end
        check("wrap_count", 32'(rcvd), 32'd10);
        check("wrap_empty", 32'(out1_count), 32'd0);

        // Reset with words buffered in both channels
        in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h7777; out1_ready = 1'b0;
        tick();
        check("prerst_out0_count", 32'(out0_count), 32'd2);
        check("prerst_out1_count", 32'(out1_count), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out0_valid", 32'(out0_valid), 32'd0);
        check("arst_out1_valid", 32'(out1_valid), 32'd0);
        check("arst_out0_count", 32'(out0_count), 32'd0);
        check("arst_out1_count", 32'(out1_count), 32'd0);
        check("arst_drop",       32'(drop_cnt),   32'd0);
        check("arst_in_ready",   32'(in_ready),   32'd1);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hBEEF; out0_ready = 1'b0;
        tick();
        check("post_rst_count", 32'(out0_count), 32'd1);
        check("post_rst_data",  32'(out0_data),  32'hBEEF);
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
